// File: rtl/framebuffer_swap_ctrl.sv
// framebuffer_swap_ctrl
// Double-buffered 3-bit framebuffer sitting behind the column renderer.
// Each frame the back buffer is flooded with the sky colour, the renderer
// is told to start, its pixel writes land in the back buffer, and the two
// buffers trade places on the first vertical-sync pulse after the renderer
// reports completion. VGA scanout reads the front buffer through a
// registered read port, so scanout never touches the buffer being drawn.

module framebuffer_swap_ctrl #(
  parameter int unsigned WIDTH     = 320,
  parameter int unsigned HEIGHT    = 240,
  parameter logic [2:0]  SKY_COLOR = 3'd5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pix_we_i,
  input  logic [8:0] pix_x_i,
  input  logic [7:0] pix_y_i,
  input  logic [2:0] pix_color_i,
  input  logic       render_done_i,
  output logic       render_ack_o,
  input  logic       vsync_start_i,
  input  logic [9:0] rd_x_i,
  input  logic [9:0] rd_y_i,
  output logic [2:0] rd_color_o,
  output logic       front_sel_o,
  output logic       frame_swapped_o
);

  localparam int unsigned NPIX      = WIDTH * HEIGHT;
  localparam logic [16:0] LAST_ADDR = 17'(NPIX - 1);
  localparam logic [9:0]  WIDTH_L   = 10'(WIDTH);
  localparam logic [9:0]  HEIGHT_L  = 10'(HEIGHT);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACK,
    S_DRAW,
    S_WAIT_VSYNC
  } state_t;

  // Linear pixel address for a 320-pixel row: y*320 = y*256 + y*64,
  // built from two shifts and an add so no multiplier is inferred.
  function automatic logic [16:0] pix_addr(input logic [7:0] y, input logic [8:0] x);
    logic [16:0] y_ext;
    y_ext = {9'd0, y};
    return (y_ext << 8) + (y_ext << 6) + {8'd0, x};
  endfunction

  state_t      state_q, state_d;
  logic [16:0] clear_addr_q, clear_addr_d;
  logic        front_sel_q, front_sel_d;
  logic        frame_swapped_q, frame_swapped_d;

  logic        pix_in_range;
  logic [16:0] pix_wr_addr;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [2:0]  wr_data;

  logic        rd_in_range;
  logic [16:0] rd_addr;
  logic [2:0]  rd0_q, rd1_q;
  logic        rd_sel_q;
  logic        rd_valid_q;

  logic [2:0]  ram0 [NPIX];
  logic [2:0]  ram1 [NPIX];

  // Renderer and scanout coordinate decoding; out-of-range reads are
  // steered to address 0 so the RAM is never indexed past its end.
  always_comb begin
    pix_in_range = ({1'b0, pix_x_i} < WIDTH_L) && ({2'b00, pix_y_i} < HEIGHT_L);
    pix_wr_addr  = pix_addr(pix_y_i, pix_x_i);
    rd_in_range  = (rd_x_i < WIDTH_L) && (rd_y_i < HEIGHT_L);
    rd_addr      = rd_in_range ? pix_addr(rd_y_i[7:0], rd_x_i[8:0]) : 17'd0;
  end

  // Frame sequencing: next state, back-buffer write port and ack pulse.
  always_comb begin
    state_d         = state_q;
    clear_addr_d    = clear_addr_q;
    front_sel_d     = front_sel_q;
    frame_swapped_d = 1'b0;
    render_ack_o    = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = clear_addr_q;
    wr_data         = SKY_COLOR;

    unique case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        if (clear_addr_q == LAST_ADDR) begin
          clear_addr_d = 17'd0;
          state_d      = S_ACK;
        end else begin
          clear_addr_d = clear_addr_q + 17'd1;
        end
      end

      S_ACK: begin
        render_ack_o = 1'b1;
        state_d      = S_DRAW;
      end

      S_DRAW: begin
        if (pix_we_i && pix_in_range) begin
          wr_en   = 1'b1;
          wr_addr = pix_wr_addr;
          wr_data = pix_color_i;
        end
        if (render_done_i) begin
          state_d = S_WAIT_VSYNC;
        end
      end

      S_WAIT_VSYNC: begin
        if (vsync_start_i) begin
          front_sel_d     = ~front_sel_q;
          frame_swapped_d = 1'b1;
          clear_addr_d    = 17'd0;
          state_d         = S_CLEAR;
        end
      end

      default: begin
        state_d      = S_CLEAR;
        clear_addr_d = 17'd0;
      end
    endcase
  end

  // Control registers; reset abandons any frame in flight and restarts the clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= S_CLEAR;
      clear_addr_q    <= 17'd0;
      front_sel_q     <= 1'b0;
      frame_swapped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_addr_q    <= clear_addr_d;
      front_sel_q     <= front_sel_d;
      frame_swapped_q <= frame_swapped_d;
    end
  end

  // Buffer 0: written only while it is the back buffer, read every cycle for scanout.
  always_ff @(posedge clk_i) begin
    if (wr_en && !reset_i && front_sel_q) begin
      ram0[wr_addr] <= wr_data;
    end
    rd0_q <= ram0[rd_addr];
  end

  // Buffer 1: written only while it is the back buffer, read every cycle for scanout.
  always_ff @(posedge clk_i) begin
    if (wr_en && !reset_i && !front_sel_q) begin
      ram1[wr_addr] <= wr_data;
    end
    rd1_q <= ram1[rd_addr];
  end

  // Remember which buffer was front and whether the read was on-screen,
  // so the registered data can be selected or blanked a cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_in_range;
      rd_sel_q   <= front_sel_q;
    end
  end

  assign rd_color_o      = rd_valid_q ? (rd_sel_q ? rd1_q : rd0_q) : 3'd0;
  assign front_sel_o     = front_sel_q;
  assign frame_swapped_o = frame_swapped_q;

endmodule

// File: doc/framebuffer_swap_ctrl.md
Name: framebuffer_swap_ctrl

Overview:
- Downstream consumer of the column renderer's pixel stream.
- Owns a double-buffered 320x240x3-bit framebuffer.
- Per frame: clears the back buffer to sky colour, handshakes the renderer to start, accepts its pixel writes, then swaps buffers on the next VGA vertical-sync pulse.
- The VGA scanout reads the front buffer through a registered read port.

Parameters:
- WIDTH, 320, visible columns
- HEIGHT, 240, visible rows
- SKY_COLOR, 3'd5, colour written to every back-buffer pixel during clear

Ports:
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- pix_we  in  1  renderer pixel write strobe
- pix_x  in  9  renderer pixel column
- pix_y  in  8  renderer pixel row
- pix_color  in  3  renderer pixel colour
- render_done  in  1  one-cycle pulse: renderer finished the frame
- render_ack  out  1  one-cycle pulse: renderer may start a frame
- vsync_start  in  1  one-cycle pulse at the start of VGA vertical blank
- rd_x  in  10  VGA scan column
- rd_y  in  10  VGA scan row
- rd_color  out  3  front-buffer colour for (rd_x, rd_y), registered
- front_sel  out  1  index of the buffer currently scanned out
- frame_swapped  out  1  one-cycle pulse on each buffer swap

Behaviour:
Reset:
- state=CLEAR, clear_addr=0, front_sel=0.
- render_ack=0, rd_color=0, frame_swapped=0.
- Reset mid-frame abandons the current frame; the next cycle restarts CLEAR at address 0.

Addressing:
- addr = y*WIDTH + x, 17 bits, computed as (y<<8)+(y<<6)+x (no multiplier).
- Back buffer is buffer ~front_sel.

State machine:
- CLEAR:
  - Each cycle, write SKY_COLOR to back[clear_addr] and increment clear_addr.
  - At clear_addr==WIDTH*HEIGHT-1 (76799), perform that write, then go to ACK.
  - pix_we is ignored.
  - Duration is exactly 76800 cycles.
- ACK:
  - render_ack=1 for exactly this one cycle, then go to DRAW.
  - pix_we is ignored.
- DRAW:
  - When pix_we=1 and pix_x<WIDTH and pix_y<HEIGHT, write pix_color to back[addr] in the same cycle.
  - Out-of-range coordinates are silently dropped.
  - A write presented in the same cycle as render_done is still performed.
  - render_done=1 -> go to WAIT_VSYNC.
  - vsync_start in DRAW is ignored, so the front buffer stays stable and tearing is impossible.
- WAIT_VSYNC:
  - pix_we is ignored.
  - vsync_start=1 -> toggle front_sel, pulse frame_swapped for one cycle, reset clear_addr to 0, go to CLEAR.
  - A vsync_start arriving in the same cycle DRAW sees render_done is not counted; a later pulse is required.

Read port:
- Registered, 1-cycle latency: rd_color at cycle n+1 equals front[rd_y*WIDTH+rd_x] at cycle n.
- rd_x>=WIDTH or rd_y>=HEIGHT -> rd_color=0 (black border).
- A swap at cycle n affects reads issued at cycle n+1 onward.

Memory:
- Two inferred 76800x3 single-write-port RAMs.
- Back-buffer writes never touch the front buffer, so read and write never target the same buffer.

Other:
- render_ack is never asserted outside ACK.
- render_done outside DRAW is ignored.

Test Plan:
- Reset, hold 76801 cycles -> render_ack pulses once, at exactly cycle 76800 after reset release; before any swap, reading back[0] and back[76799] via the bench backdoor returns 3'd5.
- In DRAW, write (x=10, y=20, color=3) then render_done, then vsync_start -> frame_swapped pulses, front_sel=1; rd_x=10, rd_y=20 returns 3 one cycle later; rd_x=11, rd_y=20 returns 5.
- Write (x=320, y=5) and (x=0, y=240) in DRAW -> no RAM change; addresses 5*320 and 0 still hold 5 after the swap.
- vsync_start pulses during DRAW and again in the render_done cycle -> no swap; the first vsync_start after render_done swaps.
- pix_we with (x=7, y=7, color=2) in the same cycle as render_done -> pixel present after the swap; rd_x=500, rd_y=0 -> rd_color=0.
- Assert Reset midway through DRAW -> front_sel=0 and render_ack=0; CLEAR restarts from 0, and render_ack next pulses at exactly cycle 76800 after Reset is released.
